// File: rtl/udp_port_demux_if.sv
// udp_port_demux_if
// Receive word stream handed over by the IP header stripper.
//   udpsof / udpeof : first / last word of a UDP datagram (qualified by udpvalidin)
//   udpvalidin      : word strobe, gaps allowed
//   udpdatain       : 16-bit big-endian datagram word
//   crcmatch        : Ethernet FCS good, meaningful on the udpeof word
//   pseudosum       : IP pseudo-header partial sum, meaningful on the udpsof word
// master drives the stream, slave (the demux) receives it.
interface udp_port_demux_if;
    logic        udpsof;
    logic        udpeof;
    logic        udpvalidin;
    logic [15:0] udpdatain;
    logic        crcmatch;
    logic [15:0] pseudosum;

    modport master (
        output udpsof, udpeof, udpvalidin, udpdatain, crcmatch, pseudosum
    );

    modport slave (
        input  udpsof, udpeof, udpvalidin, udpdatain, crcmatch, pseudosum
    );
endinterface

// File: rtl/udp_port_demux.sv
// udp_port_demux
// Parses the 8-byte UDP header, matches the destination port against
// NUM_PORTS configured ports, verifies the ones-complement checksum (seeded
// with the IP pseudo-header sum) and either decodes a fixed-length control
// datagram into start/stop/sequence events or forwards the payload as a
// framed stream tagged with the matched port index.
// Ports:
//   clock, reset        : system clock, asynchronous active-high reset
//   rx                  : receive word stream (slave side)
//   portlist            : port i at bits [16i+15:16i]
//   startvalid, stopvalid, sequencevalid, sequenceno, value : control events
//   payvalid, paysof, payeof, paydata, payport : payload stream, 1-cycle latency
//   checksummatch, pkterr : one-cycle verdict pulses
//   dropcount           : saturating count of dropped datagrams
module udp_port_demux #(
    parameter int          NUM_PORTS     = 2,
    parameter logic [15:0] CTRL_LEN      = 16'd10,
    parameter int          CTRL_PORT_IDX = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    udp_port_demux_if.slave          rx,
    input  logic [16*NUM_PORTS-1:0]  portlist,
    output logic                     startvalid,
    output logic                     stopvalid,
    output logic                     sequencevalid,
    output logic [14:0]              sequenceno,
    output logic                     value,
    output logic                     payvalid,
    output logic                     paysof,
    output logic                     payeof,
    output logic [15:0]              paydata,
    output logic [2:0]               payport,
    output logic                     checksummatch,
    output logic                     pkterr,
    output logic [15:0]              dropcount
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_CTRL    = 3'd2,
        ST_PAY     = 3'd3,
        ST_DROP    = 3'd4,
        ST_VERDICT = 3'd5
    } state_t;

    // Ones-complement add: 17-bit sum with the carry folded back into bit 0.
    function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    state_t      state_r, state_nx;
    logic [15:0] wcnt_r, wcnt_nx;
    logic [15:0] acc_r, acc_nx;
    logic [15:0] len_r, len_nx;
    logic [2:0]  idx_r, idx_nx;
    logic        nocsum_r, nocsum_nx;
    logic [15:0] ctrlw_r, ctrlw_nx;

    logic        startvalid_nx, stopvalid_nx, sequencevalid_nx, value_nx;
    logic [14:0] sequenceno_nx;
    logic        payvalid_nx, paysof_nx, payeof_nx;
    logic [15:0] paydata_nx;
    logic [2:0]  payport_nx;
    logic        checksummatch_nx, pkterr_nx;
    logic [15:0] dropcount_nx;

    logic        match_s;
    logic [2:0]  match_idx_s;
    logic [15:0] wcnt_inc_s;
    logic [15:0] acc_sum_s;
    logic [15:0] exp_words_s;
    logic        len_ok_s;
    logic        csum_ok_s;
    logic        ok_s;
    logic [15:0] ctrl_word_s;
    logic        drop_inc_s;

    // Lowest-index port match: scan downwards so the lowest hit is written last.
    always_comb begin
        match_s     = 1'b0;
        match_idx_s = 3'd0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (portlist[16*i +: 16] == rx.udpdatain) begin
                match_s     = 1'b1;
                match_idx_s = 3'(i);
            end else begin
                match_idx_s = match_idx_s;
            end
        end
    end

    // Per-word arithmetic: running checksum, word count and verdict terms.
    always_comb begin
        wcnt_inc_s  = wcnt_r + 16'd1;
        acc_sum_s   = csum_add(acc_r, rx.udpdatain);
        // ceil(length/2) words, computed without overflowing 16 bits
        exp_words_s = {1'b0, len_r[15:1]} + {15'd0, len_r[0]};
        len_ok_s    = (exp_words_s == wcnt_inc_s);
        csum_ok_s   = (acc_sum_s == 16'hFFFF) | nocsum_r;
        ok_s        = csum_ok_s & rx.crcmatch & len_ok_s;
        ctrl_word_s = (wcnt_r == 16'd4) ? rx.udpdatain : ctrlw_r;
    end

    // Next-state and registered-output decode for the parser FSM.
    always_comb begin
        state_nx         = (state_r == ST_VERDICT) ? ST_IDLE : state_r;
        wcnt_nx          = wcnt_r;
        acc_nx           = acc_r;
        len_nx           = len_r;
        idx_nx           = idx_r;
        nocsum_nx        = nocsum_r;
        ctrlw_nx         = ctrlw_r;
        startvalid_nx    = 1'b0;
        stopvalid_nx     = 1'b0;
        sequencevalid_nx = 1'b0;
        sequenceno_nx    = sequenceno;
        value_nx         = value;
        payvalid_nx      = 1'b0;
        paysof_nx        = 1'b0;
        payeof_nx        = 1'b0;
        paydata_nx       = paydata;
        payport_nx       = payport;
        checksummatch_nx = 1'b0;
        pkterr_nx        = 1'b0;
        drop_inc_s       = 1'b0;

        if (rx.udpvalidin && rx.udpsof) begin
            // A new datagram preempts a payload frame in flight: close it with
            // an empty terminating word flagged bad so downstream discards it.
            if (state_r == ST_PAY) begin
                payvalid_nx = 1'b1;
                paysof_nx   = (wcnt_r == 16'd4);
                payeof_nx   = 1'b1;
                paydata_nx  = 16'h0000;
                pkterr_nx   = 1'b1;
            end else begin
                payvalid_nx = 1'b0;
            end
            acc_nx    = csum_add(rx.pseudosum, rx.udpdatain);
            wcnt_nx   = 16'd1;
            nocsum_nx = 1'b0;
            if (rx.udpeof) begin
                drop_inc_s = 1'b1;
                state_nx   = ST_IDLE;
            end else begin
                state_nx   = ST_HDR;
            end
        end else if (rx.udpvalidin) begin
            case (state_r)
                ST_HDR: begin
                    wcnt_nx = wcnt_inc_s;
                    acc_nx  = acc_sum_s;
                    // eof anywhere in the header (even on the checksum word)
                    // leaves nothing to verify against: treat as a runt.
                    if (rx.udpeof) begin
                        drop_inc_s = 1'b1;
                        state_nx   = ST_IDLE;
                    end else if (wcnt_r == 16'd1) begin
                        idx_nx     = match_idx_s;
                        drop_inc_s = ~match_s;
                        state_nx   = match_s ? ST_HDR : ST_DROP;
                    end else if (wcnt_r == 16'd2) begin
                        len_nx = rx.udpdatain;
                    end else begin
                        nocsum_nx = (rx.udpdatain == 16'h0000);
                        if (len_r < 16'd8) begin
                            drop_inc_s = 1'b1;
                            state_nx   = ST_DROP;
                        end else if ((idx_r == 3'(CTRL_PORT_IDX)) && (len_r == CTRL_LEN)) begin
                            state_nx = ST_CTRL;
                        end else begin
                            state_nx = ST_PAY;
                        end
                    end
                end
                ST_CTRL: begin
                    wcnt_nx  = wcnt_inc_s;
                    acc_nx   = acc_sum_s;
                    ctrlw_nx = ctrl_word_s;
                    if (rx.udpeof) begin
                        state_nx = ST_VERDICT;
                        if (ok_s) begin
                            checksummatch_nx = 1'b1;
                            sequenceno_nx    = ctrl_word_s[15:1];
                            value_nx         = ctrl_word_s[0];
                            startvalid_nx    = (ctrl_word_s[15:1] == 15'd0) & ~ctrl_word_s[0];
                            stopvalid_nx     = (ctrl_word_s[15:1] == 15'd0) &  ctrl_word_s[0];
                            sequencevalid_nx = (ctrl_word_s[15:1] != 15'd0) & ~ctrl_word_s[0];
                        end else begin
                            pkterr_nx  = 1'b1;
                            drop_inc_s = 1'b1;
                        end
                    end else begin
                        state_nx = ST_CTRL;
                    end
                end
                ST_PAY: begin
                    wcnt_nx     = wcnt_inc_s;
                    acc_nx      = acc_sum_s;
                    payvalid_nx = 1'b1;
                    paysof_nx   = (wcnt_r == 16'd4);
                    payeof_nx   = rx.udpeof;
                    paydata_nx  = rx.udpdatain;
                    payport_nx  = idx_r;
                    if (rx.udpeof) begin
                        state_nx         = ST_VERDICT;
                        checksummatch_nx = ok_s;
                        pkterr_nx        = ~ok_s;
                    end else begin
                        state_nx = ST_PAY;
                    end
                end
                ST_DROP: begin
                    wcnt_nx  = wcnt_inc_s;
                    state_nx = rx.udpeof ? ST_IDLE : ST_DROP;
                end
                default: begin
                    // IDLE / VERDICT: stray words without sof are ignored
                    wcnt_nx = wcnt_r;
                end
            endcase
        end else begin
            wcnt_nx = wcnt_r;
        end

        dropcount_nx = (drop_inc_s && (dropcount != 16'hFFFF)) ? dropcount + 16'd1 : dropcount;
    end

    // State, datapath and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            wcnt_r        <= 16'd0;
            acc_r         <= 16'd0;
            len_r         <= 16'd0;
            idx_r         <= 3'd0;
            nocsum_r      <= 1'b0;
            ctrlw_r       <= 16'd0;
            startvalid    <= 1'b0;
            stopvalid     <= 1'b0;
            sequencevalid <= 1'b0;
            sequenceno    <= 15'd0;
            value         <= 1'b0;
            payvalid      <= 1'b0;
            paysof        <= 1'b0;
            payeof        <= 1'b0;
            paydata       <= 16'd0;
            payport       <= 3'd0;
            checksummatch <= 1'b0;
            pkterr        <= 1'b0;
            dropcount     <= 16'd0;
        end else begin
            state_r       <= state_nx;
            wcnt_r        <= wcnt_nx;
            acc_r         <= acc_nx;
            len_r         <= len_nx;
            idx_r         <= idx_nx;
            nocsum_r      <= nocsum_nx;
            ctrlw_r       <= ctrlw_nx;
            startvalid    <= startvalid_nx;
            stopvalid     <= stopvalid_nx;
            sequencevalid <= sequencevalid_nx;
            sequenceno    <= sequenceno_nx;
            value         <= value_nx;
            payvalid      <= payvalid_nx;
            paysof        <= paysof_nx;
            payeof        <= payeof_nx;
            paydata       <= paydata_nx;
            payport       <= payport_nx;
            checksummatch <= checksummatch_nx;
            pkterr        <= pkterr_nx;
            dropcount     <= dropcount_nx;
        end
    end

endmodule

// File: tb/tb_udp_port_demux.sv
// tb_udp_port_demux
// Directed frames with hand-computed checksums (pseudosum 0x1111, source
// port 0x0400). Expected output events are queued by the stimulus; a monitor
// on the falling clock edge pops and compares every cycle the DUT shows one.
module tb_udp_port_demux;

    typedef struct packed {
        logic        pv;
        logic        ps;
        logic        pe;
        logic [15:0] pd;
        logic [2:0]  pp;
        logic        cm;
        logic        err;
        logic        st;
        logic        sp;
        logic        sq;
        logic [14:0] sn;
        logic        v;
    } ev_t;

    logic        clock;
    logic        reset;
    logic [31:0] portlist;
    logic        startvalid, stopvalid, sequencevalid, value;
    logic [14:0] sequenceno;
    logic        payvalid, paysof, payeof;
    logic [15:0] paydata;
    logic [2:0]  payport;
    logic        checksummatch, pkterr;
    logic [15:0] dropcount;

    udp_port_demux_if rx ();

    udp_port_demux #(
        .NUM_PORTS     (2),
        .CTRL_LEN      (16'd10),
        .CTRL_PORT_IDX (0)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rx            (rx),
        .portlist      (portlist),
        .startvalid    (startvalid),
        .stopvalid     (stopvalid),
        .sequencevalid (sequencevalid),
        .sequenceno    (sequenceno),
        .value         (value),
        .payvalid      (payvalid),
        .paysof        (paysof),
        .payeof        (payeof),
        .paydata       (paydata),
        .payport       (payport),
        .checksummatch (checksummatch),
        .pkterr        (pkterr),
        .dropcount     (dropcount)
    );

    ev_t         ev_q[$];
    logic [15:0] drop_q[$];
    logic        zero_q[$];
    logic        fin_req;
    logic [14:0] exp_sn;
    logic        exp_v;
    int          n_cmp;
    int          n_bad;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected summary");
        $fatal(1);
    end

    task automatic drive(input logic sof, input logic eof, input logic [15:0] d);
        rx.udpvalidin = 1'b1;
        rx.udpsof     = sof;
        rx.udpeof     = eof;
        rx.udpdatain  = d;
        @(posedge clock);
        #1;
        rx.udpvalidin = 1'b0;
        rx.udpsof     = 1'b0;
        rx.udpeof     = 1'b0;
    endtask

    task automatic idle(input int n);
        rx.udpvalidin = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    // header (src 0x0400, dst, len, csum) followed by one or two payload words
    task automatic frame(input logic [15:0] dst, input logic [15:0] len, input logic [15:0] cs,
                         input int npay, input logic [15:0] p0, input logic [15:0] p1,
                         input logic gap);
        drive(1'b1, 1'b0, 16'h0400);
        drive(1'b0, 1'b0, dst);
        drive(1'b0, 1'b0, len);
        drive(1'b0, 1'b0, cs);
        if (npay == 1) begin
            drive(1'b0, 1'b1, p0);
        end else begin
            drive(1'b0, 1'b0, p0);
            if (gap) idle(1);
            drive(1'b0, 1'b1, p1);
        end
    endtask

    task automatic exp_pay(input logic sof, input logic eof, input logic [15:0] d,
                           input logic cm, input logic err);
        ev_t e;
        e     = '0;
        e.pv  = 1'b1;
        e.ps  = sof;
        e.pe  = eof;
        e.pd  = d;
        e.pp  = 3'd1;
        e.cm  = cm;
        e.err = err;
        e.sn  = exp_sn;
        e.v   = exp_v;
        ev_q.push_back(e);
    endtask

    task automatic exp_ctl(input logic cm, input logic err, input logic st,
                           input logic sp, input logic sq);
        ev_t e;
        e     = '0;
        e.cm  = cm;
        e.err = err;
        e.st  = st;
        e.sp  = sp;
        e.sq  = sq;
        e.sn  = exp_sn;
        e.v   = exp_v;
        ev_q.push_back(e);
    endtask

    // Monitor / scoreboard: the only process that compares and counts.
    initial begin : monitor
        ev_t         act;
        ev_t         exp;
        logic [15:0] dexp;
        logic        zdummy;
        n_cmp = 0;
        n_bad = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                if (zero_q.size() > 0) begin
                    zdummy = zero_q.pop_front();
                    n_cmp++;
                    if ({startvalid, stopvalid, sequencevalid, sequenceno, value, payvalid, paysof,
                         payeof, paydata, payport, checksummatch, pkterr, dropcount} != '0) begin
                        n_bad++;
                        $display("FAIL reset_outputs: got pv=%b pd=%h pp=%0d sn=%0d drop=%0d, expected all zero",
                                 payvalid, paydata, payport, sequenceno, dropcount);
                    end
                end
            end else begin
                act     = '0;
                act.pv  = payvalid;
                act.ps  = paysof;
                act.pe  = payeof;
                act.pd  = payvalid ? paydata : 16'h0000;
                act.pp  = payvalid ? payport : 3'd0;
                act.cm  = checksummatch;
                act.err = pkterr;
                act.st  = startvalid;
                act.sp  = stopvalid;
                act.sq  = sequencevalid;
                act.sn  = sequenceno;
                act.v   = value;
                if (act.pv | act.ps | act.pe | act.cm | act.err | act.st | act.sp | act.sq) begin
                    n_cmp++;
                    if (ev_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_output @%0t: got %h, expected no output", $time, act);
                    end else begin
                        exp = ev_q.pop_front();
                        if (act !== exp) begin
                            n_bad++;
                            $display("FAIL output_event @%0t: got %h, expected %h", $time, act, exp);
                        end
                    end
                end
                if (drop_q.size() > 0) begin
                    dexp = drop_q.pop_front();
                    n_cmp++;
                    if (dropcount !== dexp) begin
                        n_bad++;
                        $display("FAIL dropcount @%0t: got %0d, expected %0d", $time, dropcount, dexp);
                    end
                end
                if (fin_req) begin
                    n_cmp++;
                    if (ev_q.size() != 0) begin
                        n_bad++;
                        $display("FAIL missing_events: got %0d events outstanding, expected 0", ev_q.size());
                    end
                    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                    $finish;
                end
            end
        end
    end

    // Stimulus
    initial begin
        reset         = 1'b1;
        fin_req       = 1'b0;
        exp_sn        = 15'd0;
        exp_v         = 1'b0;
        portlist      = {16'd5000, 16'd4000};
        rx.udpvalidin = 1'b0;
        rx.udpsof     = 1'b0;
        rx.udpeof     = 1'b0;
        rx.udpdatain  = 16'h0000;
        rx.crcmatch   = 1'b1;
        rx.pseudosum  = 16'h1111;
        zero_q.push_back(1'b1);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        drop_q.push_back(16'd0);
        idle(2);

        // good payload to port 5000 (index 1), gap between payload words
        exp_pay(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
        exp_pay(1'b0, 1'b1, 16'hABCD, 1'b1, 1'b0);
        frame(16'h1388, 16'h000C, 16'h1959, 2, 16'h1234, 16'hABCD, 1'b1);
        idle(2);

        // control: start, stop, sequence 3, seq!=0 with value 1
        exp_sn = 15'd0; exp_v = 1'b0;
        exp_ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        frame(16'h0FA0, 16'h000A, 16'hDB44, 1, 16'h0000, 16'h0000, 1'b0);
        idle(2);
        exp_sn = 15'd0; exp_v = 1'b1;
        exp_ctl(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        frame(16'h0FA0, 16'h000A, 16'hDB43, 1, 16'h0001, 16'h0000, 1'b0);
        idle(2);
        exp_sn = 15'd3; exp_v = 1'b0;
        exp_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        frame(16'h0FA0, 16'h000A, 16'hDB3E, 1, 16'h0006, 16'h0000, 1'b0);
        idle(2);
        exp_sn = 15'd3; exp_v = 1'b1;
        exp_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(16'h0FA0, 16'h000A, 16'hDB3D, 1, 16'h0007, 16'h0000, 1'b0);
        idle(2);

        // control with checksum off by one: pkterr only, one drop
        exp_ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        frame(16'h0FA0, 16'h000A, 16'hDB45, 1, 16'h0000, 16'h0000, 1'b0);
        idle(2);
        drop_q.push_back(16'd1);
        idle(1);

        // unknown destination port, then a 3-word runt: silent drops
        frame(16'h2222, 16'h000C, 16'h0000, 2, 16'h0001, 16'h0002, 1'b0);
        idle(1);
        drive(1'b1, 1'b0, 16'h0400);
        drive(1'b0, 1'b0, 16'h1388);
        drive(1'b0, 1'b1, 16'h000C);
        idle(2);
        drop_q.push_back(16'd3);
        idle(1);

        // carry out of bit 15: no checksum, then a correct nonzero checksum
        exp_pay(1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        exp_pay(1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
        frame(16'h1388, 16'h000C, 16'h0000, 2, 16'hFFFF, 16'h0001, 1'b0);
        idle(2);
        exp_pay(1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        exp_pay(1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
        frame(16'h1388, 16'h000C, 16'hD759, 2, 16'hFFFF, 16'h0001, 1'b0);
        idle(2);

        // length field says 7 words but only 6 arrive (checksum still good)
        exp_pay(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
        exp_pay(1'b0, 1'b1, 16'hABCD, 1'b0, 1'b1);
        frame(16'h1388, 16'h000E, 16'h1957, 2, 16'h1234, 16'hABCD, 1'b0);
        idle(2);

        // bad FCS on an otherwise good frame
        rx.crcmatch = 1'b0;
        exp_pay(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
        exp_pay(1'b0, 1'b1, 16'hABCD, 1'b0, 1'b1);
        frame(16'h1388, 16'h000C, 16'h1959, 2, 16'h1234, 16'hABCD, 1'b0);
        rx.crcmatch = 1'b1;
        idle(2);

        // sof mid-payload: aborted frame closes with payeof+pkterr, next parses
        exp_pay(1'b1, 1'b0, 16'h1111, 1'b0, 1'b0);
        exp_pay(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
        exp_pay(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
        exp_pay(1'b0, 1'b1, 16'hABCD, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 16'h0400);
        drive(1'b0, 1'b0, 16'h1388);
        drive(1'b0, 1'b0, 16'h000C);
        drive(1'b0, 1'b0, 16'h1959);
        drive(1'b0, 1'b0, 16'h1111);
        frame(16'h1388, 16'h000C, 16'h1959, 2, 16'h1234, 16'hABCD, 1'b0);
        idle(2);

        // sof in the verdict cycle of a control frame
        exp_sn = 15'd0; exp_v = 1'b0;
        exp_ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_pay(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
        exp_pay(1'b0, 1'b1, 16'hABCD, 1'b1, 1'b0);
        frame(16'h0FA0, 16'h000A, 16'hDB44, 1, 16'h0000, 16'h0000, 1'b0);
        frame(16'h1388, 16'h000C, 16'h1959, 2, 16'h1234, 16'hABCD, 1'b0);
        idle(2);
        drop_q.push_back(16'd3);
        idle(1);

        // reset mid-frame: first payload word appears, then no payeof
        exp_pay(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h0400);
        drive(1'b0, 1'b0, 16'h1388);
        drive(1'b0, 1'b0, 16'h000C);
        drive(1'b0, 1'b0, 16'h1959);
        drive(1'b0, 1'b0, 16'h1234);
        @(negedge clock);
        #1;
        reset  = 1'b1;
        exp_sn = 15'd0;
        exp_v  = 1'b0;
        zero_q.push_back(1'b1);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        drop_q.push_back(16'd0);
        idle(2);

        // clean frame after reset
        exp_pay(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
        exp_pay(1'b0, 1'b1, 16'hABCD, 1'b1, 1'b0);
        frame(16'h1388, 16'h000C, 16'h1959, 2, 16'h1234, 16'hABCD, 1'b0);
        idle(10);
        fin_req = 1'b1;
    end

endmodule
